// File: rtl/debounce_multi.sv
// Multi-channel switch debouncer with a shared tick prescaler.
// Each channel provides a clean level, rise/fall pulses, a long-press pulse and optional auto-repeat.
module debounce_multi #(
    parameter int NCH          = 4,
    parameter int TICK_DIV     = 1000,
    parameter int TBITS        = 10,
    parameter int DB_TICKS     = 200,
    parameter int NBITS        = 8,
    parameter int LONG_TICKS   = 1000,
    parameter int REPEAT_TICKS = 250,
    parameter int LBITS        = 12
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [NCH-1:0] i_noisy,
    output logic [NCH-1:0] o_clean,
    output logic [NCH-1:0] o_rise,
    output logic [NCH-1:0] o_fall,
    output logic [NCH-1:0] o_long_press,
    output logic [NCH-1:0] o_repeat,
    output logic           o_tick
);

    localparam logic [TBITS-1:0] TDIV_M1 = TBITS'(TICK_DIV - 1);
    localparam logic [NBITS-1:0] DB_C    = NBITS'(DB_TICKS);
    localparam logic [LBITS-1:0] LONG_C  = LBITS'(LONG_TICKS);
    localparam logic [LBITS-1:0] REP_C   = LBITS'(REPEAT_TICKS);
    localparam bit               REP_EN  = (REPEAT_TICKS > 0);

    logic [TBITS-1:0] r_pcnt;
    logic             w_tick;

    logic [NCH-1:0]   r_sync1;
    logic [NCH-1:0]   r_sync2;
    logic [NCH-1:0]   r_xnew;
    logic [NCH-1:0]   r_clean;
    logic [NCH-1:0]   r_rise;
    logic [NCH-1:0]   r_fall;
    logic [NCH-1:0]   r_long;
    logic [NCH-1:0]   r_rep;
    logic [NCH-1:0]   r_reached;
    logic [NBITS-1:0] r_dcnt [NCH];
    logic [LBITS-1:0] r_hcnt [NCH];
    logic [LBITS-1:0] r_rcnt [NCH];

    logic [NCH-1:0]   w_stable;
    logic [NCH-1:0]   w_commit;
    logic [NCH-1:0]   w_fall_now;

    assign w_tick = (r_pcnt == TDIV_M1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pcnt <= '0;
        end else if (w_tick) begin
            r_pcnt <= '0;
        end else begin
            r_pcnt <= r_pcnt + 1'b1;
        end
    end

    always_comb begin
        w_stable   = '0;
        w_commit   = '0;
        w_fall_now = '0;
        for (int i = 0; i < NCH; i++) begin
            w_stable[i]   = (r_sync2[i] == r_xnew[i]);
            w_commit[i]   = w_stable[i] && (r_dcnt[i] == DB_C) && (r_clean[i] != r_xnew[i]);
            w_fall_now[i] = w_commit[i] && !r_xnew[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_xnew    <= '0;
            r_clean   <= '0;
            r_rise    <= '0;
            r_fall    <= '0;
            r_long    <= '0;
            r_rep     <= '0;
            r_reached <= '0;
            for (int i = 0; i < NCH; i++) begin
                r_dcnt[i] <= '0;
                r_hcnt[i] <= '0;
                r_rcnt[i] <= '0;
            end
        end else begin
            r_sync1 <= i_noisy;
            r_sync2 <= r_sync1;
            r_rise  <= '0;
            r_fall  <= '0;
            r_long  <= '0;
            r_rep   <= '0;
            for (int i = 0; i < NCH; i++) begin
                if (!w_stable[i]) begin
                    r_xnew[i] <= r_sync2[i];
                    r_dcnt[i] <= '0;
                end else if (w_commit[i]) begin
                    r_clean[i] <= r_xnew[i];
                    r_rise[i]  <= r_xnew[i];
                    r_fall[i]  <= !r_xnew[i];
                end else if (w_tick && (r_dcnt[i] < DB_C)) begin
                    r_dcnt[i] <= r_dcnt[i] + 1'b1;
                end

                // The fall cycle counts as released so no hold pulse can coincide with fall.
                if (!r_clean[i] || w_fall_now[i]) begin
                    r_hcnt[i]    <= '0;
                    r_rcnt[i]    <= '0;
                    r_reached[i] <= 1'b0;
                end else if (w_tick) begin
                    if (r_hcnt[i] < LONG_C) begin
                        r_hcnt[i] <= r_hcnt[i] + 1'b1;
                        if (r_hcnt[i] + 1'b1 == LONG_C) begin
                            r_long[i]    <= 1'b1;
                            r_reached[i] <= 1'b1;
                        end
                    end
                    if (REP_EN && r_reached[i]) begin
                        if (r_rcnt[i] + 1'b1 == REP_C) begin
                            r_rep[i]  <= 1'b1;
                            r_rcnt[i] <= '0;
                        end else begin
                            r_rcnt[i] <= r_rcnt[i] + 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign o_clean      = r_clean;
    assign o_rise       = r_rise;
    assign o_fall       = r_fall;
    assign o_long_press = r_long;
    assign o_repeat     = r_rep;
    assign o_tick       = w_tick;

endmodule

// File: doc/debounce_multi.md
Name: debounce_multi

Overview:
Multi-channel debouncer and button-event generator for front-panel switches and push-buttons. Each channel is synchronised and debounced against a shared tick prescaler, so debounce time is set in ticks rather than raw clocks. Each channel produces a clean level, one-cycle rise and fall pulses, a long-press pulse, and optional auto-repeat pulses. It sits between the board I/O pins and the control FSMs.

Parameters:
NCH, 4, number of independent input channels
TICK_DIV, 1000, clk cycles per tick (>=1; 1 = tick every cycle)
TBITS, 10, prescaler width; TICK_DIV-1 < 2^TBITS
DB_TICKS, 200, ticks input must stay stable before clean follows (>=1)
NBITS, 8, debounce counter width; DB_TICKS < 2^NBITS
LONG_TICKS, 1000, ticks clean must stay high before long_press (>=1)
REPEAT_TICKS, 250, tick period of repeat pulses after long_press; 0 disables repeat
LBITS, 12, hold/repeat counter width; LONG_TICKS and REPEAT_TICKS < 2^LBITS

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
noisy  in  NCH  raw asynchronous inputs, bit i = channel i
clean  out  NCH  debounced level per channel
rise  out  NCH  one-cycle pulse when clean goes 0->1
fall  out  NCH  one-cycle pulse when clean goes 1->0
long_press  out  NCH  one-cycle pulse when clean has been high for LONG_TICKS ticks
repeat  out  NCH  one-cycle pulse every REPEAT_TICKS ticks after long_press while held
tick  out  1  prescaler tick, one cycle wide, for observability

Behaviour:
- Reset is synchronous, active-high, on clock clk. While reset is high:
  - all synchroniser flops, candidate registers, counters and outputs go to 0;
  - the prescaler is cleared.
  - Outputs in the cycle after reset deasserts: all 0.
  - An input held high through reset yields a normal rise after the debounce latency.
- Reset mid-operation aborts all in-flight debounce, hold and repeat counts. No pulse is emitted in or after the reset cycle.
- Prescaler:
  - counter 0..TICK_DIV-1, wraps to 0;
  - tick=1 in cycles where counter==TICK_DIV-1;
  - TICK_DIV=1 gives tick constantly 1.
- Synchroniser: 2 flops per channel. sync2 is the debouncer input.
- Per-channel debounce, evaluated in priority order each cycle:
  1. If sync2 != xnew: xnew<=sync2, dcnt<=0.
  2. Else if dcnt==DB_TICKS and clean != xnew: clean<=xnew. Assert rise if xnew=1, fall if xnew=0, in the same cycle clean changes.
  3. Else if tick and dcnt<DB_TICKS: dcnt<=dcnt+1. dcnt saturates at DB_TICKS.
- Any change of sync2 restarts the count. Glitches shorter than DB_TICKS ticks never reach clean.
- Latency with TICK_DIV=1: clean/rise assert DB_TICKS+4 edges after the first edge sampling the new stable level.
- Hold logic per channel:
  - hcnt<=0 and long reached flag<=0 whenever clean==0, including the fall cycle.
  - While clean==1 and tick and hcnt<LONG_TICKS: hcnt++.
  - long_press pulses in the cycle hcnt becomes LONG_TICKS, and the reached flag sets.
  - With TICK_DIV=1, long_press occurs exactly LONG_TICKS cycles after rise.
- Repeat logic per channel (only if REPEAT_TICKS>0):
  - After the reached flag sets, rcnt increments on tick.
  - When rcnt becomes REPEAT_TICKS, repeat pulses and rcnt<=0.
  - rcnt is cleared with hcnt.
  - First repeat is REPEAT_TICKS ticks after long_press.
  - If REPEAT_TICKS=0, repeat stays 0.
- Fall while long_press/repeat counting: counts clear, no further pulses. rise and fall are never both high on a channel.
- Channels are fully independent. Simultaneous events on multiple channels are all reported in the same cycle.
- All outputs are registered. Pulses are exactly one cycle.

Test Plan:
1. TICK_DIV=1, DB_TICKS=4, noisy[0] 0->1 held -> clean[0] and rise[0] high 8 edges after first sampling edge; rise[0] low next cycle; other channels stay 0.
2. TICK_DIV=1, DB_TICKS=4, noisy[1] pulses high for 3 cycles, twice, 2 cycles apart -> clean[1], rise[1], fall[1] never assert.
3. TICK_DIV=4, DB_TICKS=3, noisy[2] stable high -> tick every 4th cycle; clean[2] rises after exactly 3 ticks past the xnew update; release -> fall[2] one cycle, clean[2]=0.
4. TICK_DIV=1, LONG_TICKS=10, REPEAT_TICKS=5, hold noisy[0] high 40 cycles -> long_press[0] 10 cycles after rise, repeat[0] at +15, +20, +25...; release -> no repeat after fall.
5. REPEAT_TICKS=0, hold 3*LONG_TICKS -> exactly one long_press pulse, repeat stays 0.
6. Reset asserted for 1 cycle mid-debounce and mid-hold on channels 0 and 3 -> all outputs 0 next cycle; held inputs produce fresh rise after full DB_TICKS+4 latency.
